// File: rtl/fullchip_seq_pkg.sv
// Shared types and constants for the fullchip instruction sequencer.
// Holds the FSM state enum, the inst word width and every inst field position.
package fullchip_seq_pkg;

    localparam int INST_W = 20;
    localparam int ADDR_W = 4;

    // Width of the host mem_in row (products per row); informational only.
    localparam int PR = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_KLOAD,
        S_QLOAD,
        S_KFETCH,
        S_EXEC,
        S_DRAIN,
        S_PSUM,
        S_NORM_ACC,
        S_NORM_DIV,
        S_DONE
    } state_e;

    // Single-bit inst fields
    localparam int BIT_SPARE    = 19;
    localparam int BIT_ACC      = 18;
    localparam int BIT_DIV      = 17;
    localparam int BIT_OFIFO_RD = 16;
    localparam int BIT_EXECUTE  = 7;
    localparam int BIT_LOAD     = 6;
    localparam int BIT_PMEM_RD  = 5;
    localparam int BIT_PMEM_WR  = 4;
    localparam int BIT_QMEM_RD  = 3;
    localparam int BIT_QMEM_WR  = 2;
    localparam int BIT_KMEM_RD  = 1;
    localparam int BIT_KMEM_WR  = 0;

    // Multi-bit address fields
    localparam int QK_ADD_HI = 15;
    localparam int QK_ADD_LO = 12;
    localparam int P_ADD_HI  = 11;
    localparam int P_ADD_LO  = 8;

endpackage

// File: rtl/fullchip_seq_cnt.sv
// seq_cnt: phase counter shared by every sequencer state.
// Synchronous clear wins over increment; increment is gated by the caller so a
// stalled phase keeps its count. tc flags that the count equals 'last'.
module seq_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt,
    output logic         tc
);

    // Next count: clear, step, or hold
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the signal unassigned (that would infer a latch).
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (inc) begin
            cnt_nxt = cnt + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            // NOTE: non-blocking assignment for flops so every register samples pre-edge values.
            cnt <= cnt_nxt;
        end
    end

    assign tc = (cnt == last);

endmodule

// File: rtl/fullchip_seq.sv
// fullchip_seq: drives the shared inst bus of fullchip through one attention
// pass (K load, Q load, K fetch, execute, drain, psum writeback, optional
// normalization) and tells the host which row to put on mem_in.
// Build option: define FULLCHIP_SEQ_NORM_EN to include NORM_ACC/NORM_DIV.
//
// A 'live' flag records whether the current cycle actually issued the word
// for state/cnt. The position only advances after it was issued, so a hold
// (which blanks the registered outputs) never drops or repeats an entry.
module fullchip_seq
    import fullchip_seq_pkg::*;
#(
    parameter int col      = 8,
    parameter int len_max  = 16,
    parameter int pipe_lat = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        q_len,
    input  logic              hold,
    output logic [INST_W-1:0] inst,
    output logic              ld_q,
    output logic              ld_k,
    output logic [ADDR_W-1:0] ld_addr,
    output logic              busy,
    output logic              done
);

    localparam int CW_A  = ($clog2(len_max) > $clog2(col)) ? $clog2(len_max) : $clog2(col);
    localparam int CNT_W = ($clog2(pipe_lat) > CW_A) ? $clog2(pipe_lat) : CW_A;

    state_e            state;
    state_e            state_nxt;
    logic              live;
    logic [3:0]        q_last;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  cnt_last;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              cnt_tc;
    logic [ADDR_W-1:0] addr_nxt;

    function automatic state_e succ(state_e s);
        case (s)
            S_KLOAD:    return S_QLOAD;
            S_QLOAD:    return S_KFETCH;
            S_KFETCH:   return S_EXEC;
            S_EXEC:     return S_DRAIN;
            S_DRAIN:    return S_PSUM;
`ifdef FULLCHIP_SEQ_NORM_EN
            S_PSUM:     return S_NORM_ACC;
            S_NORM_ACC: return S_NORM_DIV;
            S_NORM_DIV: return S_DONE;
`else
            S_PSUM:     return S_DONE;
`endif
            default:    return S_IDLE;
        endcase
    endfunction

    function automatic logic [INST_W-1:0] encode(state_e s, logic [ADDR_W-1:0] a);
        logic [INST_W-1:0] w;
        w = '0;
        case (s)
            S_KLOAD: begin
                w[BIT_KMEM_WR]           = 1'b1;
                w[QK_ADD_HI:QK_ADD_LO]   = a;
            end
            S_QLOAD: begin
                w[BIT_QMEM_WR]           = 1'b1;
                w[QK_ADD_HI:QK_ADD_LO]   = a;
            end
            S_KFETCH: begin
                w[BIT_KMEM_RD]           = 1'b1;
                w[BIT_LOAD]              = 1'b1;
                w[QK_ADD_HI:QK_ADD_LO]   = a;
            end
            S_EXEC: begin
                w[BIT_QMEM_RD]           = 1'b1;
                w[BIT_EXECUTE]           = 1'b1;
                w[QK_ADD_HI:QK_ADD_LO]   = a;
            end
            S_PSUM: begin
                w[BIT_OFIFO_RD]          = 1'b1;
                w[BIT_PMEM_WR]           = 1'b1;
                w[P_ADD_HI:P_ADD_LO]     = a;
            end
`ifdef FULLCHIP_SEQ_NORM_EN
            S_NORM_ACC: begin
                w[BIT_PMEM_RD]           = 1'b1;
                w[BIT_ACC]               = 1'b1;
                w[P_ADD_HI:P_ADD_LO]     = a;
            end
            S_NORM_DIV: begin
                w[BIT_PMEM_RD]           = 1'b1;
                w[BIT_DIV]               = 1'b1;
                w[P_ADD_HI:P_ADD_LO]     = a;
            end
`endif
            default: w = '0;
        endcase
        return w;
    endfunction

    // Last count value of the current phase
    always_comb begin
        cnt_last = '0;
        case (state)
            S_KLOAD, S_KFETCH:                             cnt_last = CNT_W'(col - 1);
            S_QLOAD, S_EXEC, S_PSUM, S_NORM_ACC, S_NORM_DIV: cnt_last = CNT_W'(q_last);
            S_DRAIN:                                       cnt_last = CNT_W'(pipe_lat - 1);
            default:                                       cnt_last = '0;
        endcase
    end

    // Next position: accept start in IDLE, otherwise step only after the current word was issued
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        if (state == S_IDLE) begin
            if (start) begin
                state_nxt = S_KLOAD;
                cnt_clr   = 1'b1;
            end
        end else if (live) begin
            if (cnt_tc) begin
                state_nxt = succ(state);
                cnt_clr   = 1'b1;
            end else begin
                cnt_inc   = 1'b1;
            end
        end
    end

    seq_cnt #(.W(CNT_W)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .last    (cnt_last),
        .cnt     (cnt),
        .cnt_nxt (cnt_nxt),
        .tc      (cnt_tc)
    );

    assign addr_nxt = ADDR_W'(cnt_nxt);

    // FSM state, issue flag, latched Q length and registered instruction outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            live    <= 1'b0;
            q_last  <= '0;
            inst    <= '0;
            ld_q    <= 1'b0;
            ld_k    <= 1'b0;
            ld_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            live  <= (state_nxt != S_IDLE) && !hold;
            busy  <= (state_nxt != S_IDLE);
            if (state == S_IDLE && start) begin
                q_last <= q_len;
            end
            if (state_nxt == S_IDLE || hold) begin
                inst    <= '0;
                ld_q    <= 1'b0;
                ld_k    <= 1'b0;
                ld_addr <= '0;
                done    <= 1'b0;
            end else begin
                inst    <= encode(state_nxt, addr_nxt);
                ld_k    <= (state_nxt == S_KLOAD);
                ld_q    <= (state_nxt == S_QLOAD);
                ld_addr <= (state_nxt == S_KLOAD || state_nxt == S_QLOAD) ? addr_nxt : '0;
                done    <= (state_nxt == S_DONE);
            end
        end
    end

endmodule
